// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial
//
// Bit-serial unsigned subtractor. Two parallel operands are captured on a
// start strobe, optionally XOR-scrambled with a fixed mask, then subtracted
// one bit per clock (LSB first) through a single borrow flip-flop. The
// parallel difference and the final borrow are presented once the last bit
// has been processed and are held until the result is acknowledged.
//
// Control sequence: IDLE -> PREP (one dead cycle) -> SUB (8 cycles) -> DONE.
//
// Parameters
//   WIDTH          operand width; fixed at 8 (the bit counter is 3 bits)
//   SCRAMBLE_MASK  XOR mask applied to both operands at load
//
// Ports
//   clk     input   1      rising-edge clock
//   rst     input   1      asynchronous active-low reset
//   en      input   1      start strobe in IDLE, acknowledge in DONE
//   a       input   WIDTH  minuend, sampled only on the load edge
//   b       input   WIDTH  subtrahend, sampled only on the load edge
//   out     output  WIDTH  difference (a_s - b_s) mod 2^WIDTH
//   borrow  output  1      final borrow, 1 iff a_s < b_s (unsigned)
//   done    output  1      high exactly while the state register is DONE
// ---------------------------------------------------------------------------
module sub_serial #(
    parameter int unsigned       WIDTH         = 8,
    parameter logic [WIDTH-1:0]  SCRAMBLE_MASK = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    // Encodings are fixed so the state register matches the adder family;
    // codes 4-7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2,
        PREP = 3'd3
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'd7;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       count;
    logic             bor;

    // One-bit full subtractor on the current LSBs.
    logic x_bit;
    logic y_bit;
    logic diff_bit;
    logic bor_next;

    always_comb begin
        x_bit    = a_reg[0];
        y_bit    = b_reg[0];
        diff_bit = x_bit ^ y_bit ^ bor;
        bor_next = (~x_bit & y_bit) | (~x_bit & bor) | (y_bit & bor);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            count <= '0;
            bor   <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg <= a ^ SCRAMBLE_MASK;
                        b_reg <= b ^ SCRAMBLE_MASK;
                        out   <= '0;
                        bor   <= 1'b0;
                        count <= '0;
                        state <= PREP;
                    end
                end

                // Dead cycle: only the state advances, en is ignored.
                PREP: begin
                    state <= SUB;
                end

                // Difference bits enter at the MSB so that after WIDTH
                // shifts the first (LSB) result bit lands in out[0].
                SUB: begin
                    bor   <= bor_next;
                    out   <= {diff_bit, out[WIDTH-1:1]};
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    count <= count + 3'd1;
                    if (count == LAST_BIT) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (en) begin
                        state <= IDLE;
                    end
                end

                // Illegal codes: data registers hold, control recovers.
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign borrow = bor;
    assign done   = (state == DONE);

endmodule
